// File: rtl/fpr_wb_queue.sv
// fpr_wb_queue -- writeback buffer in front of the FPR register file write port.
//
// FPU results from multi-cycle producers are queued in order and retired at
// most one per clock into the register file. While a result waits in the
// queue its value is forwarded to the Rs/Rt/Rn operand read ports, so decode
// can bypass instead of stalling.
//
// Ports:
//   clock, reset                 system clock, synchronous active-high reset
//   inValid/inId/inVal/inMode64  producer result; inReady = a slot is free
//   wbHold                       suppresses retirement this cycle
//   wbFlush                      discards every queued entry at the next edge
//   regIdRo/regValRo/regStMode   register file write port (IDLE_ID when idle)
//   fwdIdRs/Rt/Rn, fwdMode64     operand read ids and read width
//   fwdHitXx/fwdValXx            newest queued value matching id and width
//   fwdStall                     a queued write to a read id has the other width
//   qOverflow                    sticky: a result arrived while the queue was full
//   qCount                       current occupancy
module fpr_wb_queue #(
    parameter int         DEPTH   = 4,
    parameter logic [6:0] IDLE_ID = 7'h7F
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     inValid,
    input  logic [6:0]               inId,
    input  logic [63:0]              inVal,
    input  logic                     inMode64,
    output logic                     inReady,
    input  logic                     wbHold,
    input  logic                     wbFlush,
    output logic [6:0]               regIdRo,
    output logic [63:0]              regValRo,
    output logic [1:0]               regStMode,
    input  logic [6:0]               fwdIdRs,
    input  logic [6:0]               fwdIdRt,
    input  logic [6:0]               fwdIdRn,
    input  logic                     fwdMode64,
    output logic                     fwdHitRs,
    output logic                     fwdHitRt,
    output logic                     fwdHitRn,
    output logic [63:0]              fwdValRs,
    output logic [63:0]              fwdValRt,
    output logic [63:0]              fwdValRn,
    output logic                     fwdStall,
    output logic                     qOverflow,
    output logic [$clog2(DEPTH):0]   qCount
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Entry storage. Every entry is visible to the forwarding search at once,
    // so the storage is plain registers rather than a RAM.
    logic [6:0]    entryId   [DEPTH];
    logic [63:0]   entryVal  [DEPTH];
    logic          entryMode [DEPTH];

    logic [AW-1:0] headReg;
    logic [AW-1:0] tailReg;
    logic [CW-1:0] countReg;
    logic          overflowReg;

    logic          doEnq;
    logic          doDrain;

    // Readiness looks only at registered occupancy: a drain in this same
    // cycle does not make room for this cycle's producer.
    assign inReady = (countReg < CW'(DEPTH));
    assign doDrain = (countReg != '0) && !wbHold;
    // A result offered during a flush is thrown away along with the queue.
    assign doEnq   = inValid && inReady && !wbFlush;

    assign qCount    = countReg;
    assign qOverflow = overflowReg;

    // Write port: the head drives the register file and pops on the same edge.
    assign regIdRo   = doDrain ? entryId[headReg]  : IDLE_ID;
    assign regValRo  = doDrain ? entryVal[headReg] : 64'd0;
    assign regStMode = {1'b0, doDrain ? entryMode[headReg] : 1'b0};

    always_ff @(posedge clock) begin
        if (reset) begin
            headReg     <= '0;
            tailReg     <= '0;
            countReg    <= '0;
            overflowReg <= 1'b0;
        end else begin
            if (inValid && !inReady) begin
                overflowReg <= 1'b1;
            end
            if (wbFlush) begin
                headReg  <= '0;
                tailReg  <= '0;
                countReg <= '0;
            end else begin
                if (doEnq) begin
                    tailReg <= tailReg + AW'(1);
                end
                if (doDrain) begin
                    headReg <= headReg + AW'(1);
                end
                countReg <= countReg + CW'(doEnq) - CW'(doDrain);
            end
        end
    end

    // Payload carries no reset: it is only ever read under the count.
    always_ff @(posedge clock) begin
        if (doEnq && !reset) begin
            entryId[tailReg]   <= inId;
            entryVal[tailReg]  <= inVal;
            entryMode[tailReg] <= inMode64;
        end
    end

    // Forwarding search, one instance per read port. Entries are walked from
    // oldest (head) to newest, so a later match overrides an earlier one and
    // the entry closest to the tail wins.
    logic [6:0] portId [3];
    assign portId[0] = fwdIdRs;
    assign portId[1] = fwdIdRt;
    assign portId[2] = fwdIdRn;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_fwd
            logic          hit;
            logic [63:0]   val;
            logic          stall;
            logic [AW-1:0] slot;

            always_comb begin
                hit   = 1'b0;
                val   = 64'd0;
                stall = 1'b0;
                slot  = '0;
                for (int k = 0; k < DEPTH; k++) begin
                    slot = headReg + AW'(k);
                    if ((CW'(k) < countReg) && (entryId[slot] == portId[gi]) &&
                        (entryId[slot] != IDLE_ID)) begin
                        if (entryMode[slot] == fwdMode64) begin
                            hit = 1'b1;
                            val = entryVal[slot];
                        end else begin
                            // Same register seen at the other width aliases
                            // part of the operand; it cannot be bypassed.
                            stall = 1'b1;
                        end
                    end
                end
            end
        end
    endgenerate

    assign fwdHitRs = g_fwd[0].hit;
    assign fwdHitRt = g_fwd[1].hit;
    assign fwdHitRn = g_fwd[2].hit;
    assign fwdValRs = g_fwd[0].val;
    assign fwdValRt = g_fwd[1].val;
    assign fwdValRn = g_fwd[2].val;
    assign fwdStall = g_fwd[0].stall | g_fwd[1].stall | g_fwd[2].stall;

endmodule

// File: tb/tb_fpr_wb_queue.sv
// Testbench for fpr_wb_queue: directed scenarios followed by randomized
// traffic, all compared cycle by cycle against a queue-based reference model.
module tb_fpr_wb_queue;

    localparam int         DEPTH    = 4;
    localparam logic [6:0] IDLE_ID  = 7'h7F;
    localparam logic [6:0] UREG_FR0 = 7'h20;

    logic        clock = 1'b0;
    logic        reset;
    logic        inValid;
    logic [6:0]  inId;
    logic [63:0] inVal;
    logic        inMode64;
    logic        inReady;
    logic        wbHold;
    logic        wbFlush;
    logic [6:0]  regIdRo;
    logic [63:0] regValRo;
    logic [1:0]  regStMode;
    logic [6:0]  fwdIdRs, fwdIdRt, fwdIdRn;
    logic        fwdMode64;
    logic        fwdHitRs, fwdHitRt, fwdHitRn;
    logic [63:0] fwdValRs, fwdValRt, fwdValRn;
    logic        fwdStall;
    logic        qOverflow;
    logic [2:0]  qCount;

    always #5 clock = ~clock;

    fpr_wb_queue #(.DEPTH(DEPTH), .IDLE_ID(IDLE_ID)) dut (
        .clock(clock), .reset(reset),
        .inValid(inValid), .inId(inId), .inVal(inVal), .inMode64(inMode64),
        .inReady(inReady), .wbHold(wbHold), .wbFlush(wbFlush),
        .regIdRo(regIdRo), .regValRo(regValRo), .regStMode(regStMode),
        .fwdIdRs(fwdIdRs), .fwdIdRt(fwdIdRt), .fwdIdRn(fwdIdRn),
        .fwdMode64(fwdMode64),
        .fwdHitRs(fwdHitRs), .fwdHitRt(fwdHitRt), .fwdHitRn(fwdHitRn),
        .fwdValRs(fwdValRs), .fwdValRt(fwdValRt), .fwdValRn(fwdValRn),
        .fwdStall(fwdStall), .qOverflow(qOverflow), .qCount(qCount)
    );

    typedef struct {
        logic [6:0]  id;
        logic [63:0] val;
        logic        m;
    } entry_t;

    entry_t modelQ[$];
    logic   modelOvf;
    int     nChecks = 0;
    int     nPass   = 0;
    int     cyc     = 0;

    function automatic logic [6:0] fr(input int n);
        return UREG_FR0 + 7'(n);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Newest queued entry with matching id and width, searched tail first.
    task automatic modelFwd(input logic [6:0] id, output logic hit, output logic [63:0] val);
        hit = 1'b0;
        val = 64'd0;
        for (int i = modelQ.size() - 1; i >= 0; i--) begin
            if (modelQ[i].id == id && modelQ[i].m == fwdMode64) begin
                hit = 1'b1;
                val = modelQ[i].val;
                break;
            end
        end
    endtask

    function automatic logic modelStall();
        logic s = 1'b0;
        foreach (modelQ[i]) begin
            if ((modelQ[i].id == fwdIdRs || modelQ[i].id == fwdIdRt ||
                 modelQ[i].id == fwdIdRn) && modelQ[i].m != fwdMode64)
                s = 1'b1;
        end
        return s;
    endfunction

    // Apply one cycle of inputs after the falling edge, then compare every
    // output against the model state before the next rising edge.
    task automatic drive(input logic v, input logic [6:0] id, input logic [63:0] val,
                         input logic m, input logic hold, input logic flush, input logic rst);
        logic        dr, h;
        logic [63:0] fv;
        @(negedge clock);
        inValid = v; inId = id; inVal = val; inMode64 = m;
        wbHold = hold; wbFlush = flush; reset = rst;
        #1;
        dr = (modelQ.size() > 0) && !hold;
        check("inReady", inReady, modelQ.size() < DEPTH);
        check("regIdRo", regIdRo, dr ? modelQ[0].id : IDLE_ID);
        check("regValRo", regValRo, dr ? modelQ[0].val : 64'd0);
        check("regStMode", regStMode, dr ? {1'b0, modelQ[0].m} : 2'b00);
        check("qCount", qCount, modelQ.size());
        check("qOverflow", qOverflow, modelOvf);
        modelFwd(fwdIdRs, h, fv);
        check("fwdHitRs", fwdHitRs, h);
        check("fwdValRs", fwdValRs, fv);
        modelFwd(fwdIdRt, h, fv);
        check("fwdHitRt", fwdHitRt, h);
        check("fwdValRt", fwdValRt, fv);
        modelFwd(fwdIdRn, h, fv);
        check("fwdHitRn", fwdHitRn, h);
        check("fwdValRn", fwdValRn, fv);
        check("fwdStall", fwdStall, modelStall());
    endtask

    // Rising edge: advance the model with the inputs that were just sampled.
    task automatic tick();
        logic rdy, dr;
        @(posedge clock);
        cyc++;
        $display("cyc %0d v=%b id=%h m=%b hold=%b flush=%b rst=%b wr=%h cnt=%0d",
                 cyc, inValid, inId, inMode64, wbHold, wbFlush, reset, regIdRo, modelQ.size());
        if (reset) begin
            modelQ.delete();
            modelOvf = 1'b0;
        end else begin
            rdy = modelQ.size() < DEPTH;
            dr  = (modelQ.size() > 0) && !wbHold;
            if (inValid && !rdy) modelOvf = 1'b1;
            if (dr) void'(modelQ.pop_front());
            if (wbFlush) modelQ.delete();
            else if (inValid && rdy) modelQ.push_back('{id: inId, val: inVal, m: inMode64});
        end
    endtask

    task automatic idle(input logic hold);
        drive(1'b0, 7'd0, 64'd0, 1'b0, hold, 1'b0, 1'b0);
    endtask

    initial begin
        logic [63:0] valA, valB;
        modelOvf = 1'b0;
        fwdIdRs = fr(3); fwdIdRt = fr(2); fwdIdRn = fr(4); fwdMode64 = 1'b0;

        // Reset
        drive(1'b0, 7'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1); tick();
        drive(1'b0, 7'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1); tick();
        idle(1'b0);
        check("rst_regIdRo", regIdRo, IDLE_ID);
        check("rst_inReady", inReady, 1'b1);
        check("rst_qCount", qCount, 3'd0);
        tick();

        // Single 32-bit write, one cycle of latency
        drive(1'b1, fr(3), 64'h0000_0000_3F80_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t1_nopass", regIdRo, IDLE_ID);
        tick();
        idle(1'b0);
        check("t1_id", regIdRo, fr(3));
        check("t1_val", regValRo[31:0], 32'h3F80_0000);
        check("t1_mode", regStMode, 2'b00);
        tick();
        idle(1'b0);
        check("t1_idle", regIdRo, IDLE_ID);
        check("t1_cnt", qCount, 3'd0);
        tick();

        // Fill under hold, overflow, then drain in order
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, fr(i), {$urandom, $urandom}, 1'b0, 1'b1, 1'b0, 1'b0);
            tick();
        end
        idle(1'b1);
        check("t2_ready", inReady, 1'b0);
        check("t2_ovf", qOverflow, 1'b1);
        check("t2_cnt", qCount, 3'd4);
        tick();
        for (int i = 0; i < 4; i++) begin
            idle(1'b0);
            check("t2_order", regIdRo, fr(i));
            tick();
        end

        // Newest-wins forwarding and width-conflict stall
        valA = 64'h0000_0000_1111_1111;
        valB = 64'h0000_0000_2222_2222;
        drive(1'b1, fr(2), valA, 1'b0, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b1, fr(2), valB, 1'b0, 1'b1, 1'b0, 1'b0); tick();
        fwdIdRs = fr(2); fwdIdRt = fr(6); fwdIdRn = IDLE_ID; fwdMode64 = 1'b0;
        idle(1'b1);
        check("t3_hit", fwdHitRs, 1'b1);
        check("t3_val", fwdValRs, valB);
        check("t3_nostall", fwdStall, 1'b0);
        tick();
        fwdMode64 = 1'b1;
        idle(1'b1);
        check("t3_hitw", fwdHitRs, 1'b0);
        check("t3_stall", fwdStall, 1'b1);
        tick();
        fwdMode64 = 1'b0;
        idle(1'b0); tick();
        idle(1'b0); tick();

        // Steady stream: one in, one out every cycle
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, fr(i % 8), {32'd0, $urandom}, 1'b0, 1'b0, 1'b0, 1'b0);
            if (i > 0) begin
                check("t4_cnt", qCount, 3'd1);
                check("t4_id", regIdRo, fr((i - 1) % 8));
            end
            tick();
        end
        idle(1'b0); tick();

        // Flush under hold, then reset in the middle of a drain
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, fr(i), {$urandom, $urandom}, 1'b1, 1'b1, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 7'd0, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0); tick();
        idle(1'b0);
        check("t5_flushcnt", qCount, 3'd0);
        check("t5_flushwr", regIdRo, IDLE_ID);
        tick();
        drive(1'b1, fr(5), 64'd55, 1'b0, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b1, fr(6), 64'd66, 1'b0, 1'b1, 1'b0, 1'b0); tick();
        idle(1'b0); tick();
        drive(1'b0, 7'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1); tick();
        idle(1'b0);
        check("t5_rstwr", regIdRo, IDLE_ID);
        check("t5_rstrdy", inReady, 1'b1);
        check("t5_rstcnt", qCount, 3'd0);
        check("t5_rstovf", qOverflow, 1'b0);
        tick();

        // 64-bit pair write
        drive(1'b1, fr(4), 64'h4000_0000_0000_0000, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        idle(1'b0);
        check("t6_mode", regStMode, 2'b01);
        check("t6_val", regValRo, 64'h4000_0000_0000_0000);
        tick();

        // Randomized traffic with a small id pool so forwarding hits often
        for (int i = 0; i < 400; i++) begin
            fwdIdRs   = fr($urandom_range(0, 7));
            fwdIdRt   = fr($urandom_range(0, 7));
            fwdIdRn   = ($urandom_range(0, 9) == 0) ? IDLE_ID : fr($urandom_range(0, 7));
            fwdMode64 = 1'($urandom_range(0, 1));
            drive(1'($urandom_range(0, 9) < 7), fr($urandom_range(0, 7)),
                  {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 19) == 0),
                  1'($urandom_range(0, 49) == 0));
            tick();
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/fpr_wb_queue.md
Name: fpr_wb_queue

Overview:
- Writeback buffer directly upstream of the FPR register file write port (regIdRo/regValRo/regStMode).
- Accepts FPU results from multi-cycle producers and buffers them in order in a small FIFO.
- Retires at most one result per clock into the register file.
- Forwards still-queued values to the operand read path, so decode can bypass instead of stalling.

Parameters:
DEPTH, 4, queue entries (power of two, >=2)
IDLE_ID, 7'h7F, register id driven on regIdRo when no write; must decode to no register in the FPR file

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
inValid  in  1  producer result valid
inId  in  7  destination register id (UREG_FRn / UREG_XFn / UREG_FPUL encoding)
inVal  in  64  result value; 32-bit results in [31:0]
inMode64  in  1  1 = 64-bit pair write, 0 = 32-bit single write
inReady  out  1  queue can accept this cycle
wbHold  in  1  pipeline hold; suppresses retirement
wbFlush  in  1  discard all queued entries
regIdRo  out  7  register file write id
regValRo  out  64  register file write data
regStMode  out  2  register file set mode; bit0 = mode64, bit1 = 0
fwdIdRs  in  7  operand read id, Rs
fwdIdRt  in  7  operand read id, Rt
fwdIdRn  in  7  operand read id, Rn
fwdMode64  in  1  read width of current operand fetch
fwdHitRs  out  1  queued value available for Rs
fwdHitRt  out  1  queued value available for Rt
fwdHitRn  out  1  queued value available for Rn
fwdValRs  out  64  forwarded value for Rs
fwdValRt  out  64  forwarded value for Rt
fwdValRn  out  64  forwarded value for Rn
fwdStall  out  1  width-conflicting pending write; decode must stall
qOverflow  out  1  sticky: enqueue attempted while full
qCount  out  log2(DEPTH)+1  current occupancy

Behaviour:
- Storage: per entry {id[6:0], val[63:0], mode64}. Registered head pointer, tail pointer and count.
- inReady = (count < DEPTH). It is derived from registered state only; a same-cycle drain does not free a slot for the current cycle.
- Enqueue: on a rising edge with inValid && inReady, the entry is written at the tail.
- Enqueue when full: inValid && !inReady drops the entry and sets qOverflow. qOverflow clears only on reset.
- Drain: when count > 0 and !wbHold, the head entry drives the write port:
  - regIdRo = head.id, regValRo = head.val, regStMode = {1'b0, head.mode64}.
  - The head pops on that rising edge; the register file captures the value on the same edge.
- No drain (count == 0 or wbHold): regIdRo = IDLE_ID, regValRo = 0, regStMode = 0.
- Latency: an entry enqueued at edge N appears on the write port during cycle N..N+1 and retires at edge N+1 at the earliest. There is no same-cycle pass-through.
- Simultaneous enqueue and drain: count is unchanged; both pointers advance.
- Pointers wrap modulo DEPTH.
- Order is strictly FIFO. Duplicate ids are allowed; the later entry overwrites later.
- Forwarding, per read port, combinational over valid queued entries only (the incoming inVal is not searched):
  - Match: entry.id == fwdId && entry.mode64 == fwdMode64. The newest matching entry (closest to the tail) wins: fwdHit = 1, fwdVal = its val.
  - An entry that is the head and retires this cycle still forwards.
  - No match: fwdHit = 0, fwdVal = 0.
  - Id match with mode mismatch on any port raises fwdStall = 1 (registers alias across widths).
  - Ids IDLE_ID and any id not present in the queue never hit.
- Flush: wbFlush empties the queue at the next edge (count = 0, head = tail = 0).
  - The write port is still driven normally in the flush cycle, so the head retires unless wbHold is asserted.
  - An enqueue in the flush cycle is discarded.
- Reset: has priority over flush and all other events.
  - count = 0, pointers = 0, qOverflow = 0.
  - Outputs after reset: inReady = 1, regIdRo = IDLE_ID, regValRo = 0, regStMode = 0, all fwdHit = 0, fwdStall = 0, qCount = 0.
  - Reset mid-operation discards all entries with no write.

Test Plan:
1. Single write: enqueue id=UREG_FR3, val=64'h0000_0000_3F80_0000, mode64=0 → next cycle regIdRo=UREG_FR3, regValRo[31:0]=32'h3F800000, regStMode=0; the following cycle regIdRo=IDLE_ID, qCount=0.
2. Full and overflow: wbHold=1, enqueue 5 results back-to-back (DEPTH=4) → inReady=0 after the 4th, the 5th is dropped, qOverflow=1, qCount=4. Release wbHold → 4 retirements in order over 4 cycles.
3. Forwarding priority: queue FR2=A, then FR2=B (mode64=0), with wbHold=1; fwdIdRs=UREG_FR2, fwdMode64=0 → fwdHitRs=1, fwdValRs=B. With fwdMode64=1 → fwdHitRs=0, fwdStall=1.
4. Steady stream: enqueue and drain every cycle for 16 cycles → qCount stays 1, regIdRo sequence matches the input sequence delayed by 1, qOverflow=0.
5. Flush and reset: 3 entries queued with wbHold=1; assert wbFlush → qCount=0 next cycle with no write. Refill 2 entries, assert reset mid-drain → regIdRo=IDLE_ID, inReady=1, qCount=0 the following cycle.
6. Pair write: enqueue id=UREG_FR4, mode64=1, val=64'h4000_0000_0000_0000 → regStMode=2'b01, regValRo equals the full 64-bit value.
